// File: rtl/float_fmt_pkg.sv
// Float format helpers shared by the operand packer and the dot-product unit.
//   LANES            lanes per packed operand vector
//   FLAG_*           bit positions inside the 3-bit {nan, inf, denorm} flag word
//   exp_w/frac_w/bias field layout for the supported element widths (32/16/8)
package float_fmt_pkg;

   localparam int LANES    = 4;
   localparam int FLAG_NAN = 2;
   localparam int FLAG_INF = 1;
   localparam int FLAG_DEN = 0;

   function automatic bit fmt_legal(int dw);
      return (dw == 32) || (dw == 16) || (dw == 8);
   endfunction

   function automatic int exp_w(int dw);
      case (dw)
         32:      return 8;
         16:      return 5;
         8:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int frac_w(int dw);
      case (dw)
         32:      return 23;
         16:      return 10;
         8:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int bias(int dw);
      return (1 << (exp_w(dw) - 1)) - 1;
   endfunction

endpackage

// File: rtl/dot_operand_packer_if.sv
// Element-stream input and packed-vector output of the operand packer.
//   master : element source / vector consumer side (drives in_*, out_ready)
//   slave  : the packer (drives in_ready, out_*)
interface dot_operand_packer_if
   import float_fmt_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic                        in_valid;
   logic                        in_ready;
   logic [DATA_WIDTH-1:0]       in_a;
   logic [DATA_WIDTH-1:0]       in_b;
   logic                        in_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES*DATA_WIDTH-1:0] out_a;
   logic [LANES*DATA_WIDTH-1:0] out_b;
   logic [2:0]                  out_count;
   logic [2:0]                  out_flags;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_count, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_a, out_b, out_count, out_flags
   );
endinterface

// File: rtl/float_classify.sv
// Combinational special-value classifier for one element.
// Only present when SPECIAL_DETECT_EN is defined (its sole user is then the packer).
//   x_i      element bits (sign | exponent | fraction)
//   flags_o  {nan, inf, denorm}
`ifdef SPECIAL_DETECT_EN
module float_classify
   import float_fmt_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] x_i,
   output logic [2:0]            flags_o
);
   localparam int EW = exp_w(DATA_WIDTH);
   localparam int FW = frac_w(DATA_WIDTH);

   logic [EW-1:0] exp_f;
   logic [FW-1:0] frac_f;

   assign exp_f  = x_i[DATA_WIDTH-2 -: EW];
   assign frac_f = x_i[FW-1:0];

   always_comb begin
      flags_o           = '0;
      flags_o[FLAG_NAN] = (&exp_f) && (|frac_f);
      flags_o[FLAG_INF] = (&exp_f) && !(|frac_f);
      flags_o[FLAG_DEN] = !(|exp_f) && (|frac_f);
   end
endmodule
`endif

// File: rtl/dot_operand_packer.sv
// Packs a serial stream of (a,b) element pairs into 4-lane operand vectors using a
// ping-pong pair of banks: one bank fills while the other is held for the consumer.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  dot_operand_packer_if.slave (in_* element stream, out_* packed vectors)
// Build option: SPECIAL_DETECT_EN adds per-bank sticky {nan, inf, denorm} flags;
// without it out_flags reads 3'b000.
module dot_operand_packer
   import float_fmt_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   dot_operand_packer_if.slave   bus
);
   localparam int VW = LANES * DATA_WIDTH;

   if (!fmt_legal(DATA_WIDTH)) begin : g_bad_width
      $error("dot_operand_packer: DATA_WIDTH must be 32, 16 or 8");
   end

   logic [VW-1:0] bank_a_q [2];
   logic [VW-1:0] bank_b_q [2];
   logic [2:0]    count_q  [2];
   logic [1:0]    full_q,    full_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    lane_q,    lane_d;

   logic in_ready_w, accept, close, consume;

   // Ready depends only on registered state so no path exists from out_ready.
   assign in_ready_w = !full_q[wr_bank_q];
   assign accept     = bus.in_valid && in_ready_w;
   assign close      = accept && ((lane_q == 2'd3) || bus.in_last);
   assign consume    = full_q[rd_bank_q] && bus.out_ready;

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = full_q[rd_bank_q];
   assign bus.out_a     = bank_a_q[rd_bank_q];
   assign bus.out_b     = bank_b_q[rd_bank_q];
   assign bus.out_count = full_q[rd_bank_q] ? count_q[rd_bank_q] : 3'd0;

`ifdef SPECIAL_DETECT_EN
   logic [2:0] flags_q [2];
   logic [2:0] cls_a, cls_b;

   float_classify #(.DATA_WIDTH(DATA_WIDTH)) u_cls_a (.x_i(bus.in_a), .flags_o(cls_a));
   float_classify #(.DATA_WIDTH(DATA_WIDTH)) u_cls_b (.x_i(bus.in_b), .flags_o(cls_b));

   assign bus.out_flags = full_q[rd_bank_q] ? flags_q[rd_bank_q] : 3'b000;
`else
   assign bus.out_flags = 3'b000;
`endif

   // A close and a consume always target different banks: a full write bank blocks
   // accepts, and an empty read bank cannot be consumed.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      lane_d    = lane_q;
      if (consume) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (accept) begin
         if (close) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            lane_d            = 2'd0;
         end else begin
            lane_d = lane_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         lane_q    <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         lane_q    <= lane_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            bank_a_q[b] <= '0;
            bank_b_q[b] <= '0;
            count_q[b]  <= '0;
`ifdef SPECIAL_DETECT_EN
            flags_q[b]  <= '0;
`endif
         end
      end else if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            if (2'(i) == lane_q) begin
               bank_a_q[wr_bank_q][i*DATA_WIDTH +: DATA_WIDTH] <= bus.in_a;
               bank_b_q[wr_bank_q][i*DATA_WIDTH +: DATA_WIDTH] <= bus.in_b;
            end else if (close && (2'(i) > lane_q)) begin
               // Short vector: pad the unused upper lanes with +0.0.
               bank_a_q[wr_bank_q][i*DATA_WIDTH +: DATA_WIDTH] <= '0;
               bank_b_q[wr_bank_q][i*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
         end
         if (close) begin
            count_q[wr_bank_q] <= {1'b0, lane_q} + 3'd1;
         end
`ifdef SPECIAL_DETECT_EN
         // First lane restarts the sticky flags of a bank being refilled.
         flags_q[wr_bank_q] <= ((lane_q == 2'd0) ? 3'b000 : flags_q[wr_bank_q]) | cls_a | cls_b;
`endif
      end
   end
endmodule

// File: tb/tb_dot_operand_packer.sv
module tb_dot_operand_packer;
   localparam int DW = 32;
   localparam int VW = 4 * DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dot_operand_packer_if #(.DATA_WIDTH(DW)) bus ();
   dot_operand_packer #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [2:0]    cnt;
      logic [2:0]    flg;
   } vec_t;

   vec_t          exp_q[$];
   logic [DW-1:0] cur_a[$];
   logic [DW-1:0] cur_b[$];

   logic          s_in_acc, s_out_acc, s_ov, s_ir;
   logic [VW-1:0] s_oa, s_ob;
   logic [2:0]    s_cnt, s_flg;

   // {nan, inf, denorm} from the binary32 field definitions
   function automatic logic [2:0] ref_class(logic [31:0] x);
      int unsigned e, f;
      e = (x >> 23) & 32'hFF;
      f = x & 32'h7F_FFFF;
      return {(e == 255) && (f != 0), (e == 255) && (f == 0), (e == 0) && (f != 0)};
   endfunction

   function automatic void model_push(logic [DW-1:0] a, logic [DW-1:0] b, logic last);
      vec_t v;
      cur_a.push_back(a);
      cur_b.push_back(b);
      if (cur_a.size() == 4 || last) begin
         v.a   = '0;
         v.b   = '0;
         v.flg = 3'b000;
         v.cnt = 3'(cur_a.size());
         for (int i = 0; i < cur_a.size(); i++) begin
            v.a[i*DW +: DW] = cur_a[i];
            v.b[i*DW +: DW] = cur_b[i];
`ifdef SPECIAL_DETECT_EN
            v.flg = v.flg | ref_class(cur_a[i]) | ref_class(cur_b[i]);
`endif
         end
         exp_q.push_back(v);
         cur_a.delete();
         cur_b.delete();
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      cur_a.delete();
      cur_b.delete();
   endfunction

   // Inputs change at posedge+1; everything the next edge acts on is sampled at negedge.
   task automatic tick();
      @(negedge clk);
      s_in_acc  = bus.in_valid && bus.in_ready;
      s_out_acc = bus.out_valid && bus.out_ready;
      s_ov      = bus.out_valid;
      s_ir      = bus.in_ready;
      s_oa      = bus.out_a;
      s_ob      = bus.out_b;
      s_cnt     = bus.out_count;
      s_flg     = bus.out_flags;
      if (s_in_acc) model_push(bus.in_a, bus.in_b, bus.in_last);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pair(logic [DW-1:0] a, logic [DW-1:0] b, logic last);
      bit done = 0;
      bus.in_a = a; bus.in_b = b; bus.in_last = last; bus.in_valid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         tick();
         if (s_in_acc) done = 1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: pair a=%h not accepted within 50 cycles, required acceptance", a);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_count, bus.out_flags} !== {1'b1, 1'b0, 3'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b count=%0d flags=%b, required 1 0 0 000",
                  bus.in_ready, bus.out_valid, bus.out_count, bus.out_flags);
      end
      n_cmp++;
      if ({bus.out_a, bus.out_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: out_a=%h out_b=%h, required zero", bus.out_a, bus.out_b);
      end
   endtask

   task automatic test_full_vector();
      logic [31:0] av [4];
      av[0] = 32'h3F800000; av[1] = 32'h40000000; av[2] = 32'h40400000; av[3] = 32'h40800000;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_pair(av[i], 32'h3F800000, 1'b0);
      n_cmp++;
      if (s_ov !== 1'b0) begin
         n_bad++; $display("FAIL full_early_valid: out_valid=%b in closing cycle, required 0", s_ov);
      end
      tick();
      n_cmp++;
      if (s_ov !== 1'b1) begin
         n_bad++; $display("FAIL full_latency: out_valid=%b one cycle after close, required 1", s_ov);
      end
      n_cmp++;
      if ({s_oa, s_ob, s_cnt, s_flg} !== {128'h40800000_40400000_40000000_3F800000,
                                          {4{32'h3F800000}}, 3'd4, 3'd0}) begin
         n_bad++;
         $display("FAIL full_data: a=%h b=%h cnt=%0d flg=%b, required a=40800000_40400000_40000000_3F800000 b=4x3F800000 cnt=4 flg=000",
                  s_oa, s_ob, s_cnt, s_flg);
      end
      if (s_out_acc && exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
      n_cmp++;
      if (s_ov !== 1'b0 || s_cnt !== 3'd0) begin
         n_bad++; $display("FAIL full_consumed: out_valid=%b count=%0d after consume, required 0 0", s_ov, s_cnt);
      end
   endtask

   task automatic test_short_vector();
      bus.out_ready = 1'b1;
      send_pair(32'h3F800000, 32'h40000000, 1'b0);
      send_pair(32'h3F800000, 32'h40000000, 1'b1);
      tick();
      n_cmp++;
      if ({s_ov, s_cnt} !== {1'b1, 3'd2}) begin
         n_bad++; $display("FAIL short_count: valid=%b cnt=%0d, required 1 2", s_ov, s_cnt);
      end
      n_cmp++;
      if ({s_oa, s_ob} !== {64'h0, 32'h3F800000, 32'h3F800000, 64'h0, 32'h40000000, 32'h40000000}) begin
         n_bad++; $display("FAIL short_pad: a=%h b=%h, required upper lanes zero", s_oa, s_ob);
      end
      if (s_out_acc && exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] da [12];
      logic [DW-1:0] db [12];
      logic [VW-1:0] held_a;
      logic [2:0]    held_c;
      vec_t          e;
      int            idx = 0;
      int            got = 0;
      for (int i = 0; i < 12; i++) begin da[i] = $urandom; db[i] = $urandom; end
      bus.out_ready = 1'b0;
      for (int c = 0; c < 14; c++) begin
         bus.in_valid = 1'b1; bus.in_a = da[idx]; bus.in_b = db[idx]; bus.in_last = 1'b0;
         tick();
         if (s_in_acc) idx++;
      end
      n_cmp++;
      if (idx !== 8 || bus.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 8 0", idx, bus.in_ready);
      end
      held_a = bus.out_a; held_c = bus.out_count;
      repeat (3) tick();
      n_cmp++;
      if ({s_ov, s_oa, s_cnt} !== {1'b1, held_a, held_c}) begin
         n_bad++; $display("FAIL bp_hold: valid=%b a=%h cnt=%0d, required held a=%h cnt=%0d",
                           s_ov, s_oa, s_cnt, held_a, held_c);
      end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.in_valid = (idx < 12);
         if (idx < 12) begin bus.in_a = da[idx]; bus.in_b = db[idx]; end
         tick();
         if (s_in_acc) idx++;
         if (s_out_acc) begin
            got++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL bp_extra: unexpected vector a=%h, required none", s_oa);
            end else begin
               e = exp_q.pop_front();
               if ({s_oa, s_ob, s_cnt, s_flg} !== {e.a, e.b, e.cnt, e.flg}) begin
                  n_bad++;
                  $display("FAIL bp_vector: a=%h b=%h cnt=%0d flg=%b, required a=%h b=%h cnt=%0d flg=%b",
                           s_oa, s_ob, s_cnt, s_flg, e.a, e.b, e.cnt, e.flg);
               end
            end
         end
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (idx !== 12 || got !== 3 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL bp_total: accepted=%0d delivered=%0d left=%0d, required 12 3 0",
                           idx, got, exp_q.size());
      end
   endtask

   task automatic test_flags();
      logic [31:0] av [4];
      logic [2:0]  want;
      av[0] = 32'h7FC00000; av[1] = 32'h7F800000; av[2] = 32'h00000001; av[3] = 32'h3F800000;
`ifdef SPECIAL_DETECT_EN
      want = 3'b111;
`else
      want = 3'b000;
`endif
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_pair(av[i], 32'h3F800000, 1'b0);
      tick();
      n_cmp++;
      if ({s_ov, s_flg} !== {1'b1, want}) begin
         n_bad++; $display("FAIL flags_special: valid=%b flags=%b, required 1 %b", s_ov, s_flg, want);
      end
      if (s_out_acc && exp_q.size() > 0) void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) send_pair(32'h3F800000, 32'h3F800000, 1'b0);
      tick();
      n_cmp++;
      if ({s_ov, s_flg} !== {1'b1, 3'b000}) begin
         n_bad++; $display("FAIL flags_clear: valid=%b flags=%b, required 1 000", s_ov, s_flg);
      end
      if (s_out_acc && exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
   endtask

   task automatic test_reset_mid();
      vec_t e;
      int   got = 0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_pair($urandom, $urandom, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.out_count, bus.in_ready} !== {1'b0, 3'd0, 1'b1}) begin
         n_bad++; $display("FAIL rstmid_now: valid=%b cnt=%0d in_ready=%b, required 0 0 1",
                           bus.out_valid, bus.out_count, bus.in_ready);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_pair($urandom, $urandom, 1'b0);
      for (int c = 0; c < 8; c++) begin
         tick();
         if (s_out_acc) begin
            got++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rstmid_extra: stale vector a=%h, required none", s_oa);
            end else begin
               e = exp_q.pop_front();
               if ({s_oa, s_ob, s_cnt} !== {e.a, e.b, e.cnt}) begin
                  n_bad++; $display("FAIL rstmid_vector: a=%h cnt=%0d, required a=%h cnt=%0d",
                                    s_oa, s_cnt, e.a, e.cnt);
               end
            end
         end
      end
      n_cmp++;
      if (got !== 1) begin
         n_bad++; $display("FAIL rstmid_count: delivered=%0d, required 1", got);
      end
   endtask

   task automatic test_random();
      logic [31:0] specials [6];
      vec_t        e;
      bit          flushed = 0;
      specials[0] = 32'h7FC00000; specials[1] = 32'hFF800000; specials[2] = 32'h00000010;
      specials[3] = 32'h80000001; specials[4] = 32'h00000000; specials[5] = 32'h3F800000;
      for (int c = 0; c < 640; c++) begin
         if (c < 600) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_last   = ($urandom_range(4) == 0);
            bus.in_a      = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            bus.in_b      = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            bus.out_ready = ($urandom_range(9) < 7);
         end else begin
            bus.in_valid  = !flushed;
            bus.in_last   = 1'b1;
            bus.out_ready = 1'b1;
         end
         tick();
         if (c >= 600 && s_in_acc) flushed = 1;
         if (s_out_acc) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rand_extra: unexpected vector a=%h, required none", s_oa);
            end else begin
               e = exp_q.pop_front();
               if ({s_oa, s_ob, s_cnt, s_flg} !== {e.a, e.b, e.cnt, e.flg}) begin
                  n_bad++;
                  $display("FAIL rand_vector: a=%h b=%h cnt=%0d flg=%b, required a=%h b=%h cnt=%0d flg=%b",
                           s_oa, s_ob, s_cnt, s_flg, e.a, e.b, e.cnt, e.flg);
               end
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || cur_a.size() != 0 || bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL rand_drain: pending=%0d partial=%0d out_valid=%b, required 0 0 0",
                           exp_q.size(), cur_a.size(), bus.out_valid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_vector();
      test_short_vector();
      test_backpressure();
      test_flags();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
